// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters, registered sync/blank/strobes
// and a fixed-latency copy of sync/blank that lines up with mapper colour outputs.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Window bounds are one bit wider than the counters so an edge at 1024 still compares correctly.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic        ACT      = (SYNC_POL != 0);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1 || PIPE_DELAY < 0) begin : g_bad_cfg
            $error("vga_timing_gen: frame does not fit 10-bit counters or PIPE_DELAY is negative");
        end
    endgenerate

    logic [9:0] x_q, x_d, y_q, y_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       vis_q, vis_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       lstart_q, lstart_d;
    logic       fstart_q, fstart_d;

    // Flags are decoded from the next counter values so, once registered, they describe the same pixel as DrawX/DrawY.
    always_comb begin
        x_d = (x_q == H_LAST) ? '0 : x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
        vis_d    = ({1'b0, x_d} < H_VIS) && ({1'b0, y_d} < V_VIS);
        hsync_d  = (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END)) ? ACT : ~ACT;
        vsync_d  = (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END)) ? ACT : ~ACT;
        lstart_d = (x_d == '0);
        fstart_d = lstart_d && (y_d == '0);
        fcnt_d   = fstart_d ? fcnt_q + 8'd1 : fcnt_q;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            vis_q    <= 1'b0;
            hsync_q  <= ~ACT;
            vsync_q  <= ~ACT;
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vis_q    <= vis_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = vis_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign line_start  = lstart_q;
    assign frame_start = fstart_q;
    assign frame_count = fcnt_q;

    generate
        if (PIPE_DELAY == 0) begin : g_nodelay
            assign hs_d    = hsync_q;
            assign vs_d    = vsync_q;
            assign blank_d = vis_q;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_pipe_q;
            logic [PIPE_DELAY-1:0] vs_pipe_q;
            logic [PIPE_DELAY-1:0] bl_pipe_q;

            // Stage 0 holds the newest sample; reset flushes every stage to the inactive level.
            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    hs_pipe_q <= {PIPE_DELAY{~ACT}};
                    vs_pipe_q <= {PIPE_DELAY{~ACT}};
                    bl_pipe_q <= '0;
                end else begin
                    hs_pipe_q[0] <= hsync_q;
                    vs_pipe_q[0] <= vsync_q;
                    bl_pipe_q[0] <= vis_q;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                        bl_pipe_q[i] <= bl_pipe_q[i-1];
                    end
                end
            end

            assign hs_d    = hs_pipe_q[PIPE_DELAY-1];
            assign vs_d    = vs_pipe_q[PIPE_DELAY-1];
            assign blank_d = bl_pipe_q[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: directed expectations keyed by cycles-since-reset-release are queued,
// and a negedge monitor pops and compares them against three differently configured DUTs.
module tb_vga_timing_gen;
    logic clk;
    logic reset;
    int   cyc;
    int   nChecks;
    int   nPass;
    int   fsCountB;

    localparam int A_X = 0, A_Y = 1, A_BLANK = 2, A_HS = 3, A_VS = 4, A_LS = 5, A_FS = 6, A_FC = 7;
    localparam int A_HSD = 8, A_VSD = 9, A_BLD = 10;
    localparam int B_VS = 11, B_VSD = 12, B_BLANK = 13, B_FS = 14, B_FC = 15, B_FSCNT = 16;
    localparam int C_HS = 17, C_HSD = 18, B_HS = 19, B_Y = 20;

    typedef struct {
        int    cyc;
        int    sel;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];

    logic [9:0] aX, aY, bX, bY, cX, cY;
    logic [7:0] aFc, bFc, cFc;
    logic aBlank, aHs, aVs, aLs, aFs, aHsd, aVsd, aBld;
    logic bBlank, bHs, bVs, bLs, bFs, bHsd, bVsd, bBld;
    logic cBlank, cHs, cVs, cLs, cFs, cHsd, cVsd, cBld;

    vga_timing_gen dutA (
        .vga_clk(clk), .reset(reset), .DrawX(aX), .DrawY(aY), .blank(aBlank), .hs(aHs), .vs(aVs),
        .line_start(aLs), .frame_start(aFs), .frame_count(aFc), .hs_d(aHsd), .vs_d(aVsd), .blank_d(aBld)
    );

    // Shrunken 16x10 raster so whole frames and the 256-frame counter wrap fit in a short run.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .PIPE_DELAY(2)
    ) dutB (
        .vga_clk(clk), .reset(reset), .DrawX(bX), .DrawY(bY), .blank(bBlank), .hs(bHs), .vs(bVs),
        .line_start(bLs), .frame_start(bFs), .frame_count(bFc), .hs_d(bHsd), .vs_d(bVsd), .blank_d(bBld)
    );

    vga_timing_gen #(.SYNC_POL(1), .PIPE_DELAY(0)) dutC (
        .vga_clk(clk), .reset(reset), .DrawX(cX), .DrawY(cY), .blank(cBlank), .hs(cHs), .vs(cVs),
        .line_start(cLs), .frame_start(cFs), .frame_count(cFc), .hs_d(cHsd), .vs_d(cVsd), .blank_d(cBld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc is 1 on the first edge after reset release, so DrawX is expected to equal (cyc-1) mod H_TOTAL.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        fsCountB = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset)    fsCountB = 0;
            else if (bFs) fsCountB = fsCountB + 1;
        end
    end

    function automatic int getActual(input int sel);
        case (sel)
            A_X:     return int'(aX);
            A_Y:     return int'(aY);
            A_BLANK: return int'(aBlank);
            A_HS:    return int'(aHs);
            A_VS:    return int'(aVs);
            A_LS:    return int'(aLs);
            A_FS:    return int'(aFs);
            A_FC:    return int'(aFc);
            A_HSD:   return int'(aHsd);
            A_VSD:   return int'(aVsd);
            A_BLD:   return int'(aBld);
            B_VS:    return int'(bVs);
            B_VSD:   return int'(bVsd);
            B_BLANK: return int'(bBlank);
            B_FS:    return int'(bFs);
            B_FC:    return int'(bFc);
            B_FSCNT: return fsCountB;
            C_HS:    return int'(cHs);
            C_HSD:   return int'(cHsd);
            B_HS:    return int'(bHs);
            B_Y:     return int'(bY);
            default: return -1;
        endcase
    endfunction

    task automatic applyStimulus(input int c, input int sel, input int v, input string n);
        chk_t e;
        int   i;
        e.cyc  = c;
        e.sel  = sel;
        e.exp  = v;
        e.name = n;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic checkOutput(input chk_t e);
        int act;
        act = getActual(e.sel);
        nChecks = nChecks + 1;
        if (act == e.exp) nPass = nPass + 1;
        else $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d", e.name, e.cyc, act, e.exp);
    endtask

    initial begin
        chk_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic pushResetChecks();
        applyStimulus(0, A_X, 799, "rst_DrawX");
        applyStimulus(0, A_Y, 524, "rst_DrawY");
        applyStimulus(0, A_BLANK, 0, "rst_blank");
        applyStimulus(0, A_HS, 1, "rst_hs");
        applyStimulus(0, A_VS, 1, "rst_vs");
        applyStimulus(0, A_FC, 0, "rst_frame_count");
        applyStimulus(0, A_LS, 0, "rst_line_start");
        applyStimulus(0, A_FS, 0, "rst_frame_start");
        applyStimulus(0, A_HSD, 1, "rst_hs_d");
        applyStimulus(0, A_VSD, 1, "rst_vs_d");
        applyStimulus(0, A_BLD, 0, "rst_blank_d");
        applyStimulus(0, C_HS, 0, "rst_pol1_hs");
        applyStimulus(0, C_HSD, 0, "rst_pol1_hs_d");
    endtask

    task automatic pushStartChecks();
        applyStimulus(1, A_X, 0, "start_DrawX");
        applyStimulus(1, A_Y, 0, "start_DrawY");
        applyStimulus(1, A_BLANK, 1, "start_blank");
        applyStimulus(1, A_FS, 1, "start_frame_start");
        applyStimulus(1, A_LS, 1, "start_line_start");
        applyStimulus(1, A_FC, 1, "start_frame_count");
        applyStimulus(1, A_BLD, 0, "start_blank_d_c1");
        applyStimulus(2, A_BLD, 0, "start_blank_d_c2");
        applyStimulus(2, A_FS, 0, "start_frame_start_drop");
        applyStimulus(2, A_LS, 0, "start_line_start_drop");
        applyStimulus(3, A_BLD, 1, "start_blank_d_c3");
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        reset   = 1'b1;

        pushResetChecks();
        pushStartChecks();
        // Line 0 of the full-size raster: blank, hs window and their 2-cycle delayed copies.
        applyStimulus(640, A_BLANK, 1, "blank_x639");
        applyStimulus(641, A_BLANK, 0, "blank_x640");
        applyStimulus(800, A_BLANK, 0, "blank_x799");
        applyStimulus(642, A_BLD, 1, "blank_d_x641");
        applyStimulus(643, A_BLD, 0, "blank_d_x642");
        applyStimulus(656, A_HS, 1, "hs_x655");
        applyStimulus(657, A_HS, 0, "hs_x656");
        applyStimulus(752, A_HS, 0, "hs_x751");
        applyStimulus(753, A_HS, 1, "hs_x752");
        applyStimulus(658, A_HSD, 1, "hs_d_x657");
        applyStimulus(659, A_HSD, 0, "hs_d_x658");
        applyStimulus(754, A_HSD, 0, "hs_d_x753");
        applyStimulus(755, A_HSD, 1, "hs_d_x754");
        applyStimulus(800, A_X, 799, "DrawX_799");
        applyStimulus(800, A_Y, 0, "DrawY_end_line0");
        applyStimulus(800, A_LS, 0, "line_start_x799");
        applyStimulus(801, A_X, 0, "DrawX_wrap");
        applyStimulus(801, A_Y, 1, "DrawY_line1");
        applyStimulus(801, A_LS, 1, "line_start_line1");
        applyStimulus(801, A_FS, 0, "frame_start_line1");
        applyStimulus(801, A_VS, 1, "vs_line1");
        applyStimulus(802, A_LS, 0, "line_start_once");
        applyStimulus(656, C_HSD, 0, "pol1_hs_d_x655");
        applyStimulus(657, C_HSD, 1, "pol1_hs_d_x656");
        applyStimulus(657, C_HS, 1, "pol1_hs_x656");
        applyStimulus(753, C_HSD, 0, "pol1_hs_d_x752");
        applyStimulus(1900, A_X, 299, "pre_rst_DrawX");
        applyStimulus(1900, A_Y, 2, "pre_rst_DrawY");
        applyStimulus(1900, A_BLD, 1, "pre_rst_blank_d");

        repeat (5) @(negedge clk);
        #2 reset = 1'b0;

        while (cyc < 1900) @(negedge clk);
        #2;
        pushResetChecks();
        pushStartChecks();
        // Small raster: sync windows, frame period and the frame_count wrap.
        applyStimulus(10, B_HS, 1, "b_hs_x9");
        applyStimulus(11, B_HS, 0, "b_hs_x10");
        applyStimulus(13, B_HS, 0, "b_hs_x12");
        applyStimulus(14, B_HS, 1, "b_hs_x13");
        applyStimulus(17, B_Y, 1, "b_DrawY_line1");
        applyStimulus(88, B_BLANK, 1, "b_blank_y5x7");
        applyStimulus(89, B_BLANK, 0, "b_blank_y5x8");
        applyStimulus(97, B_BLANK, 0, "b_blank_y6");
        applyStimulus(112, B_VS, 1, "b_vs_y6");
        applyStimulus(113, B_VS, 0, "b_vs_y7");
        applyStimulus(144, B_VS, 0, "b_vs_y8");
        applyStimulus(145, B_VS, 1, "b_vs_y9");
        applyStimulus(114, B_VSD, 1, "b_vs_d_lag1");
        applyStimulus(115, B_VSD, 0, "b_vs_d_lag2");
        applyStimulus(146, B_VSD, 0, "b_vs_d_end_lag1");
        applyStimulus(147, B_VSD, 1, "b_vs_d_end_lag2");
        applyStimulus(160, B_FS, 0, "b_frame_start_before");
        applyStimulus(160, B_FC, 1, "b_frame_count_f0");
        applyStimulus(161, B_FS, 1, "b_frame_start_f1");
        applyStimulus(161, B_FC, 2, "b_frame_count_f1");
        applyStimulus(161, B_BLANK, 1, "b_blank_f1");
        applyStimulus(40800, B_FC, 255, "b_frame_count_255");
        applyStimulus(40801, B_FC, 0, "b_frame_count_wrap0");
        applyStimulus(40801, B_FS, 1, "b_frame_start_f255");
        applyStimulus(40961, B_FC, 1, "b_frame_count_wrap1");
        applyStimulus(40961, B_FS, 1, "b_frame_start_f256");
        applyStimulus(40961, B_FSCNT, 257, "b_frame_start_pulses");

        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        while (sb.size() > 0 && cyc < 41100) @(negedge clk);
        #2;
        while (sb.size() > 0) begin
            chk_t e;
            e = sb.pop_front();
            nChecks = nChecks + 1;
            $display("[TB] FAIL %s @cyc %0d: never compared, expected %0d", e.name, e.cyc, e.exp);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
